upsample2d2x_nearest: RTL and testbench
=======================================

Name: upsample2d2x_nearest

Overview:
Nearest-neighbour 2x2 upsampler with stride 2, the decoder-side inverse of the 2x2 stride-2 max-pool stage.
- Consumes a raster stream of an (IMG_SIZE/2) x (IMG_SIZE/2) feature map.
- Emits an IMG_SIZE x IMG_SIZE raster stream where each input pixel covers a 2x2 output block.
- Uses valid/ready on both sides, because the output rate is 4x the input rate.
- Sits between decoder conv stages in the pixel-stream pipeline.

Parameters:
DATA_WIDTH, 32, pixel word width (opaque bits, no arithmetic).
IMG_SIZE, 100, output image side; must be even and >= 4.
IN_SIZE (localparam), IMG_SIZE/2, input image side, also the row buffer depth.

Ports:
Clk  input  1  single clock, all state updates on rising edge.
Rst  input  1  synchronous, active-high reset.
data_in  input  DATA_WIDTH  input pixel.
valid_in  input  1  data_in is valid.
ready_in  output  1  block accepts data_in this cycle (combinational).
data_out  output  DATA_WIDTH  output pixel (registered).
valid_out  output  1  data_out is valid (registered).
ready_out  input  1  downstream accepts data_out this cycle.
eol_out  output  1  qualifies the last beat of each output row (registered, valid only with valid_out).
eof_out  output  1  qualifies the last beat of the output frame (registered, valid only with valid_out).

Behaviour:
- Reset (Rst=1 at a rising edge), wins over everything else:
  - data_out=0, valid_out=0, eol_out=0, eof_out=0.
  - state=ROW_NEW; col=0; phase=0; row=0.
  - ready_in is forced 0 while Rst=1.
  - Row buffer contents are don't-care.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as pixel (0,0).
- Load condition:
  - load = !valid_out || ready_out.
  - The output register takes a new beat only on load.
  - Otherwise data_out, valid_out, eol_out and eof_out hold stable.
- Each load is one output beat. phase toggles per load: 0 = first horizontal copy, 1 = second copy.
- State ROW_NEW (first output row of a pair):
  - ready_in = load && phase==0.
  - On input handshake: data_out<=data_in, valid_out<=1, buf[col]<=data_in, phase<=1.
  - phase==1 && load: re-issue the same pixel (data_out unchanged, valid_out=1), phase<=0, col++.
  - If phase==0 and there is no input handshake while load: valid_out<=0 (bubble).
  - After the phase-1 beat with col==IN_SIZE-1: col<=0, state<=ROW_REPEAT, eol_out=1 on that beat.
- State ROW_REPEAT (second output row of a pair):
  - ready_in=0.
  - Each load: data_out<=buf[col], valid_out<=1, and phase toggles.
  - col increments after the phase-1 beat.
  - The phase-1 beat at col==IN_SIZE-1 sets eol_out=1, then: col<=0, state<=ROW_NEW.
    - If row==IN_SIZE-1: eof_out=1 on that beat and row<=0.
    - Otherwise row++.
- Latency: the first copy of an accepted pixel appears on data_out the cycle after the input handshake.
- Throughput with ready_out held 1: one output beat per cycle. ready_in is high on every other cycle in ROW_NEW and low for all of ROW_REPEAT, so at most IN_SIZE input accepts per 2*IMG_SIZE cycles.
- Backpressure: with ready_out=0 and valid_out=1, all outputs hold and no counter advances. ready_in stays 0 because load=0.
- Row buffer: IN_SIZE x DATA_WIDTH register array, one write port, combinational read indexed by col.
  - Within the same cycle, a write and read at the same address cannot occur, since writes happen only in ROW_NEW and reads only in ROW_REPEAT.
- Frames are back-to-back: after the eof beat, the next ROW_NEW accepts pixel (0,0) of the next frame immediately.

Decomposition:
- Shared package holds:
  - state enum {ROW_NEW, ROW_REPEAT};
  - the IN_SIZE derivation;
  - counter width function clog2(IN_SIZE).
- Natural sub-module: upsample_row_buffer (parameters DEPTH, DATA_WIDTH; ports Clk, we, waddr, wdata, raddr, rdata). Reusable by a later bilinear variant.

Test Plan:
- IMG_SIZE=4, ready_out=1, input 1,2,3,4 -> output beats 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4; eol_out on beats 4,8,12,16; eof_out only on beat 16.
- Same stimulus with ready_out toggling 1,0,1,0,... -> identical beat sequence; data_out and valid_out stable during every ready_out=0 cycle; no input accepted while valid_out=1 && ready_out=0.
- Continuous valid_in=1, ready_out=1, IMG_SIZE=4 -> ready_in pattern per row pair: 1,0,1,0 then 0,0,0,0; exactly 4 inputs accepted per 16 output beats.
- valid_in gaps (one-cycle bubbles between pixels) in ROW_NEW -> valid_out drops for matching cycles; ROW_REPEAT is unaffected and runs gap-free.
- Rst pulsed after input pixel 3 of frame, then new frame 5,6,7,8 -> valid_out=0 the cycle after reset; output is 5,5,6,6,5,5,6,6,7,7,8,8,7,7,8,8.
- Two back-to-back frames, IMG_SIZE=8, random data and random ready_out -> output matches reference nearest-upsample model; eof_out exactly once per 64 beats.

Source files
------------

// File: rtl/upsample2d2x_nearest_pkg.sv
// upsample2d2x_nearest_pkg: shared state encoding and size helpers for the 2x nearest upsampler
package upsample2d2x_nearest_pkg;
  typedef enum logic {ROW_NEW, ROW_REPEAT} state_e;
  function automatic int in_size(input int img);
    return img / 2;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/upsample_row_buffer.sv
// upsample_row_buffer: one-row register array, single write port, combinational read
module upsample_row_buffer
  import upsample2d2x_nearest_pkg::*;
#(
  parameter int DEPTH = 50,
  parameter int DATA_WIDTH = 32,
  parameter int AW = cnt_w(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  // contents need no reset: every entry is written in ROW_NEW before ROW_REPEAT reads it
  always_ff @(posedge Clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/upsample2d2x_nearest.sv
// upsample2d2x_nearest: streams each input pixel out as a 2x2 block of an IMG_SIZE x IMG_SIZE raster
module upsample2d2x_nearest
  import upsample2d2x_nearest_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE = 100
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic                  eol_out,
  output logic                  eof_out
);
  localparam int IN_SIZE = in_size(IMG_SIZE);
  localparam int CW = cnt_w(IN_SIZE);
  localparam logic [CW-1:0] LAST = CW'(IN_SIZE - 1);
  state_e state_q, state_d;
  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic phase_q, phase_d, valid_q, valid_d, eol_q, eol_d, eof_q, eof_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rd;
  logic load, hs, last_col, eop, rep;
  assign load = !valid_q || ready_out;
  assign rep = state_q == ROW_REPEAT;
  assign ready_in = !Rst && load && !rep && !phase_q;
  assign hs = valid_in && ready_in;
  assign last_col = col_q == LAST;
  assign eop = load && phase_q;
  // next state: phase-1 beats advance the column, the last one flips the row half
  always_comb begin
    state_d = eop && last_col ? (rep ? ROW_NEW : ROW_REPEAT) : state_q;
    col_d = eop ? (last_col ? '0 : col_q + 1'b1) : col_q;
    row_d = eop && last_col && rep ? (row_q == LAST ? '0 : row_q + 1'b1) : row_q;
    phase_d = (phase_q || rep ? load : hs) ? !phase_q : phase_q;
    data_d = !load ? data_q : rep ? rd : hs ? data_in : data_q;
    valid_d = !load ? valid_q : rep || phase_q || hs;
    eol_d = !load ? eol_q : phase_q && last_col;
    eof_d = !load ? eof_q : phase_q && last_col && rep && row_q == LAST;
  end
  // FSM and registered output beat
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ROW_NEW;
      col_q <= '0;
      row_q <= '0;
      phase_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      eol_q <= 1'b0;
      eof_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      phase_q <= phase_d;
      data_q <= data_d;
      valid_q <= valid_d;
      eol_q <= eol_d;
      eof_q <= eof_d;
    end
  end
  upsample_row_buffer #(.DEPTH(IN_SIZE), .DATA_WIDTH(DATA_WIDTH)) u_buf (
    .Clk(Clk), .we(hs), .waddr(col_q), .wdata(data_in), .raddr(col_q), .rdata(rd)
  );
  assign data_out = data_q;
  assign valid_out = valid_q;
  assign eol_out = eol_q;
  assign eof_out = eof_q;
endmodule

// File: tb/tb_upsample2d2x_nearest.sv
// tb_upsample2d2x_nearest: table, directed and randomized checks against a nearest-upsample model
module tb_upsample2d2x_nearest;
  typedef struct packed {logic [31:0] d; logic eol; logic eof;} beat_t;
  typedef struct {logic [31:0] din; logic [31:0] d; logic eol; logic eof;} vec_t;
  logic clk = 0, rst = 1, vin = 0, rout = 1, sel = 0;
  logic [31:0] din = '0;
  logic ri4, ri8, v4, v8, l4, l8, f4, f8;
  logic [31:0] d4, d8;
  logic ri, vout, eol, eof;
  logic [31:0] dout;
  int checks = 0, failures = 0, bubbles, acc16;
  beat_t got[$], exp_q[$];
  logic ri_tr[$];

  always #5 clk = ~clk;

  upsample2d2x_nearest #(.DATA_WIDTH(32), .IMG_SIZE(4)) u4 (
    .Clk(clk), .Rst(rst), .data_in(din), .valid_in(vin), .ready_in(ri4),
    .data_out(d4), .valid_out(v4), .ready_out(rout), .eol_out(l4), .eof_out(f4));
  upsample2d2x_nearest #(.DATA_WIDTH(32), .IMG_SIZE(8)) u8 (
    .Clk(clk), .Rst(rst), .data_in(din), .valid_in(vin), .ready_in(ri8),
    .data_out(d8), .valid_out(v8), .ready_out(rout), .eol_out(l8), .eof_out(f8));

  assign ri = sel ? ri8 : ri4;
  assign vout = sel ? v8 : v4;
  assign dout = sel ? d8 : d4;
  assign eol = sel ? l8 : l4;
  assign eof = sel ? f8 : f4;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  // reference: output pixel (oy,ox) of each frame is input pixel (oy/2,ox/2)
  task automatic model(input logic [31:0] px[$], input int img);
    int n = img / 2;
    exp_q.delete();
    for (int f = 0; f < px.size() / (n * n); f++)
      for (int oy = 0; oy < img; oy++)
        for (int ox = 0; ox < img; ox++)
          exp_q.push_back('{px[f*n*n + (oy/2)*n + ox/2], ox == img-1, ox == img-1 && oy == img-1});
  endtask

  task automatic compare(input string nm);
    chk({nm, "_len"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  task automatic do_reset();
    rst = 1; vin = 0; rout = 1;
    repeat (2) begin
      @(negedge clk); #1;
      chk("rst_outputs", {dout, vout, eol, eof}, 0);
      chk("rst_ready_in", ri, 0);
    end
    @(negedge clk);
    rst = 0;
  endtask

  // rmode: 0 ready_out=1, 1 toggling 1,0,..., 2 random; gap<0 gives random idle cycles between pixels
  task automatic run(input logic [31:0] px[$], input int rmode, input int gap, input int nexp);
    int idx = 0, idle = 0, cyc = 0;
    logic stall = 0;
    beat_t held = '0;
    got.delete(); ri_tr.delete(); bubbles = 0; acc16 = 0;
    while (got.size() < nexp && cyc < 4000) begin
      @(negedge clk);
      if (idle > 0) begin vin = 0; idle--; end else vin = idx < px.size();
      din = vin ? px[idx] : '0;
      rout = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 0) : ($urandom_range(3) != 0);
      #1;
      cyc++;
      if (stall) chk("stall_hold", {dout, vout, eol, eof}, {held.d, 1'b1, held.eol, held.eof});
      if (vout && !rout) chk("stall_no_accept", ri, 0);
      ri_tr.push_back(ri);
      if (!vout && got.size() > 0) bubbles++;
      if (vout && rout) got.push_back('{dout, eol, eof});
      if (vin && ri) begin
        idx++;
        idle = gap < 0 ? int'($urandom_range(2)) : gap;
        if (cyc <= 16) acc16++;
      end
      stall = vout && !rout;
      held = '{dout, eol, eof};
    end
    chk("done_in_time", got.size() >= nexp, 1);
  endtask

  initial begin
    vec_t tbl[16];
    int dv[16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
    logic [31:0] px[$];
    int neof;
    for (int i = 0; i < 16; i++) tbl[i] = '{i < 4 ? i + 1 : 0, dv[i], i % 4 == 3, i == 15};
    for (int i = 0; i < 4; i++) px.push_back(tbl[i].din);

    sel = 0;
    do_reset();
    run(px, 0, 0, 16);
    chk("tbl_len", 64'(got.size()), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("tbl_beat%0d", i), {got[i].d, got[i].eol, got[i].eof}, {tbl[i].d, tbl[i].eol, tbl[i].eof});

    do_reset();
    run(px, 1, 0, 16);
    chk("toggle_len", 64'(got.size()), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("toggle_beat%0d", i), {got[i].d, got[i].eol, got[i].eof}, {tbl[i].d, tbl[i].eol, tbl[i].eof});

    do_reset();
    px = '{1, 2, 3, 4, 5, 6, 7, 8};
    model(px, 4);
    run(px, 0, 0, 32);
    compare("cont");
    for (int i = 0; i < 16 && i < ri_tr.size(); i++)
      chk($sformatf("cont_ready_in%0d", i), ri_tr[i], (i % 8 < 4) && (i % 2 == 0));
    chk("cont_accepts16", 64'(acc16), 4);

    do_reset();
    px = '{1, 2, 3, 4};
    model(px, 4);
    run(px, 0, 2, 16);
    compare("gap");
    chk("gap_bubbles", 64'(bubbles), 2);

    do_reset();
    px = '{1, 2, 3};
    run(px, 0, 0, 9);
    chk("pre_rst_beat9", got.size() == 9 ? got[8].d : 32'hx, 3);
    @(negedge clk);
    rst = 1; vin = 0;
    @(negedge clk); #1;
    chk("midrst_valid_out", vout, 0);
    chk("midrst_ready_in", ri, 0);
    @(negedge clk);
    rst = 0;
    px = '{5, 6, 7, 8};
    model(px, 4);
    run(px, 0, 0, 16);
    compare("midrst");

    sel = 1;
    do_reset();
    px.delete();
    for (int i = 0; i < 32; i++) px.push_back($urandom);
    model(px, 8);
    run(px, 2, -1, 128);
    compare("rand");
    neof = 0;
    foreach (got[i]) if (got[i].eof) neof++;
    chk("rand_eof_count", 64'(neof), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
